arm_exc_seq: RTL and testbench
==============================

ARM_EXC_SEQ -- requirements
Module: arm_exc_seq

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning):
- DATA_WIDTH, 32, register/PSR width.
- ADDR_WIDTH, 4, logical register address width.
- BYTES, DATA_WIDTH/8, byte-enable width.

REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- Clk, in, 1, the single clock; all state updates on the rising edge.
- Rst, in, 1, synchronous, active-high reset.
- exc_req, in, 7, level exception requests: [0] reset, [1] undef, [2] swi, [3] prefetch abort, [4] data abort, [5] irq, [6] fiq.
- ret_addr, in, DATA_WIDTH, link value for R14 of the new mode (computed by the pipeline).
- CPSR_cur, in, DATA_WIDTH, current CPSR read back from the register file.
- CPSR_in, out, DATA_WIDTH, new CPSR value.
- CPSR_write_en, out, 1, CPSR write strobe.
- CPSR_byte_w_en, out, BYTES, CPSR byte enables.
- SPSR_in, out, DATA_WIDTH, SPSR value for the new mode.
- SPSR_write_en, out, 1, SPSR write strobe.
- SPSR_byte_w_en, out, BYTES, SPSR byte enables.
- Rd_w_addr, out, ADDR_WIDTH, logical write address.
- Rd_in, out, DATA_WIDTH, write data.
- Rd_byte_w_en, out, BYTES, Rd byte enables.
- PC_in, out, DATA_WIDTH, vector address.
- pc_load, out, 1, PC load strobe.
- busy, out, 1, sequence in progress; pipeline stalls.
- exc_ack, out, 7, one-hot acknowledge of the taken exception.

Function
REQ-003 The FSM SHALL have four states, IDLE, SWITCH, BANK and VECTOR, encoded as the team chooses.

REQ-004 In IDLE, the FSM SHALL compute the effective request as exc_req, with bit 5 cleared when CPSR_cur[7]=1 and bit 6 cleared when CPSR_cur[6]=1.

REQ-005 Priority SHALL be reset > data abort > fiq > irq > prefetch abort > undef > swi; when undef and swi are both set, undef SHALL win.

REQ-006 On a clock edge in IDLE with a non-zero effective request, the block SHALL perform the following, then enter SWITCH:
- latch the winner (one-hot);
- latch old_cpsr = CPSR_cur;
- latch ret_addr.

REQ-007 Mode, vector and F-bit per winner SHALL be:

| Winner | Mode | Vector | F |
|---|---|---|---|
| reset | 10011 | 0x00 | 1 |
| undef | 11011 | 0x04 | unchanged |
| swi | 10011 | 0x08 | unchanged |
| prefetch abort | 10111 | 0x0C | unchanged |
| data abort | 10111 | 0x10 | unchanged |
| irq | 10010 | 0x18 | unchanged |
| fiq | 10001 | 0x1C | 1 |

REQ-008 In SWITCH, the block SHALL drive CPSR_write_en=1 and CPSR_byte_w_en=all ones, with CPSR_in = old_cpsr modified as follows:
- [4:0] = new mode;
- [5] T = 0;
- [7] I = 1;
- [6] F per REQ-007.

REQ-009 SWITCH SHALL precede BANK, so that the register file bank mapping reflects the new mode before banked writes.

REQ-010 In BANK, the block SHALL drive the following simultaneously:
- SPSR_write_en=1, SPSR_byte_w_en=all ones, SPSR_in=old_cpsr;
- Rd_w_addr=14, Rd_in=latched ret_addr, Rd_byte_w_en=all ones.

REQ-011 In VECTOR, the block SHALL drive:
- pc_load=1;
- PC_in = vector, zero-extended to DATA_WIDTH;
- exc_ack = latched one-hot winner, for exactly one cycle;
- next state IDLE.

REQ-012 Latency SHALL be as follows, for a request sampled at edge k:
- CPSR write in cycle k+1;
- SPSR/R14 writes in cycle k+2;
- PC load and ack in cycle k+3;
- IDLE from cycle k+4.

REQ-013 busy SHALL be 1 in SWITCH, BANK and VECTOR, and 0 in IDLE.

REQ-014 exc_req SHALL be ignored outside IDLE; a request still asserted when the FSM returns to IDLE SHALL be re-arbitrated using the new CPSR_cur masks.

REQ-015 Whenever a strobe is 0, its byte enables SHALL be 0; all data outputs SHALL be 0 when not in their active state.

REQ-016 Only the latched CPSR SHALL be used after IDLE; changes to CPSR_cur mid-sequence SHALL have no effect on the sequence.

Reset
REQ-017 When Rst=1 at a clock edge, the block SHALL do the following on that edge, from any state (including mid-sequence):
- FSM -> IDLE;
- latched winner, old_cpsr and ret_addr -> 0;
- all outputs 0 from the next cycle.

REQ-018 A sequence aborted by Rst SHALL NOT complete any remaining writes, and SHALL NOT assert exc_ack.

REQ-019 In the cycle after Rst deasserts, the block SHALL accept requests.

Verification
REQ-020 IRQ, CPSR_cur=0x00000010, ret_addr=0x104 -> the bench SHALL check:
- cycle k+1: CPSR_in=0x00000092;
- cycle k+2: SPSR_in=0x10, Rd_w_addr=14, Rd_in=0x104;
- cycle k+3: PC_in=0x18, exc_ack=0x20;
- busy high for 3 cycles.

REQ-021 exc_req=0x70 (data abort+irq+fiq), CPSR_cur=0x10 -> data abort taken:
- CPSR_in=0x00000097;
- PC_in=0x10;
- exc_ack=0x10.

REQ-022 IRQ with CPSR_cur=0x00000093 -> masked: busy stays 0, no strobes; FIQ with CPSR_cur=0x00000093 -> CPSR_in=0x000000D1, PC_in=0x1C.

REQ-023 Rst asserted in BANK -> no SPSR/Rd write completes, no pc_load, no exc_ack; all outputs 0 next cycle; IDLE afterwards.

REQ-024 swi held high for the whole sequence, CPSR_cur updated to 0x93 -> a second SWI is taken starting in cycle k+4, with SPSR_in=0x93; undef+swi together -> PC_in=0x04.

Source files
------------

// File: rtl/arm_exc_seq.sv
// ARM exception entry sequencer.
// Arbitrates requests, then writes CPSR, SPSR/R14, and loads the vector.
module arm_exc_seq #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int BYTES      = DATA_WIDTH / 8
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [6:0]            exc_req,
  input  logic [DATA_WIDTH-1:0] ret_addr,
  input  logic [DATA_WIDTH-1:0] CPSR_cur,
  output logic [DATA_WIDTH-1:0] CPSR_in,
  output logic                  CPSR_write_en,
  output logic [BYTES-1:0]      CPSR_byte_w_en,
  output logic [DATA_WIDTH-1:0] SPSR_in,
  output logic                  SPSR_write_en,
  output logic [BYTES-1:0]      SPSR_byte_w_en,
  output logic [ADDR_WIDTH-1:0] Rd_w_addr,
  output logic [DATA_WIDTH-1:0] Rd_in,
  output logic [BYTES-1:0]      Rd_byte_w_en,
  output logic [DATA_WIDTH-1:0] PC_in,
  output logic                  pc_load,
  output logic                  busy,
  output logic [6:0]            exc_ack
);

  typedef enum logic [1:0] {
    IDLE,
    SWITCH,
    BANK,
    VECTOR
  } state_t;

  state_t state_q, state_d;

  logic [6:0]            eff;
  logic [6:0]            pick;
  logic [6:0]            win_q;
  logic [DATA_WIDTH-1:0] old_q;
  logic [DATA_WIDTH-1:0] ret_q;
  logic [4:0]            mode;
  logic [4:0]            vec;
  logic                  fset;

  // I masks irq, F masks fiq
  assign eff = exc_req & ~{CPSR_cur[6], CPSR_cur[7], 5'b0};

  // Fixed-priority pick: rst > dabt > fiq > irq > pabt > und > swi
  always_comb begin
    pick = '0;
    if (eff[0])      pick[0] = 1'b1;
    else if (eff[4]) pick[4] = 1'b1;
    else if (eff[6]) pick[6] = 1'b1;
    else if (eff[5]) pick[5] = 1'b1;
    else if (eff[3]) pick[3] = 1'b1;
    else if (eff[1]) pick[1] = 1'b1;
    else if (eff[2]) pick[2] = 1'b1;
  end

  // State and sequence context registers
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      win_q   <= '0;
      old_q   <= '0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && eff != '0) begin
        win_q <= pick;
        old_q <= CPSR_cur;
        ret_q <= ret_addr;
      end
    end
  end

  // Next-state sequencing
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (eff != '0) state_d = SWITCH;
      SWITCH:  state_d = BANK;
      BANK:    state_d = VECTOR;
      VECTOR:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Mode, vector and F-bit decode of the latched winner
  always_comb begin
    mode = 5'b0;
    vec  = 5'h00;
    fset = 1'b0;
    unique case (1'b1)
      win_q[0]: begin mode = 5'b10011; vec = 5'h00; fset = 1'b1; end
      win_q[1]: begin mode = 5'b11011; vec = 5'h04; end
      win_q[2]: begin mode = 5'b10011; vec = 5'h08; end
      win_q[3]: begin mode = 5'b10111; vec = 5'h0C; end
      win_q[4]: begin mode = 5'b10111; vec = 5'h10; end
      win_q[5]: begin mode = 5'b10010; vec = 5'h18; end
      win_q[6]: begin mode = 5'b10001; vec = 5'h1C; fset = 1'b1; end
      default: begin mode = 5'b0; vec = 5'h00; fset = 1'b0; end
    endcase
  end

  // Per-state outputs; everything idles at zero
  always_comb begin
    CPSR_in        = '0;
    CPSR_write_en  = 1'b0;
    CPSR_byte_w_en = '0;
    SPSR_in        = '0;
    SPSR_write_en  = 1'b0;
    SPSR_byte_w_en = '0;
    Rd_w_addr      = '0;
    Rd_in          = '0;
    Rd_byte_w_en   = '0;
    PC_in          = '0;
    pc_load        = 1'b0;
    busy           = 1'b0;
    exc_ack        = '0;
    unique case (state_q)
      IDLE: ;
      SWITCH: begin
        busy           = 1'b1;
        CPSR_write_en  = 1'b1;
        CPSR_byte_w_en = '1;
        CPSR_in        = {old_q[DATA_WIDTH-1:8], 1'b1,
                          fset | old_q[6], 1'b0, mode};
      end
      BANK: begin
        busy           = 1'b1;
        SPSR_write_en  = 1'b1;
        SPSR_byte_w_en = '1;
        SPSR_in        = old_q;
        Rd_w_addr      = ADDR_WIDTH'(14);
        Rd_in          = ret_q;
        Rd_byte_w_en   = '1;
      end
      VECTOR: begin
        busy    = 1'b1;
        pc_load = 1'b1;
        PC_in   = DATA_WIDTH'(vec);
        exc_ack = win_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_arm_exc_seq.sv
// Directed bench for arm_exc_seq.
// Vector table for single entries, hand sequences for reset/hold cases.
module tb_arm_exc_seq;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [6:0]  exc_req;
  logic [31:0] ret_addr;
  logic [31:0] CPSR_cur;
  logic [31:0] CPSR_in;
  logic        CPSR_write_en;
  logic [3:0]  CPSR_byte_w_en;
  logic [31:0] SPSR_in;
  logic        SPSR_write_en;
  logic [3:0]  SPSR_byte_w_en;
  logic [3:0]  Rd_w_addr;
  logic [31:0] Rd_in;
  logic [3:0]  Rd_byte_w_en;
  logic [31:0] PC_in;
  logic        pc_load;
  logic        busy;
  logic [6:0]  exc_ack;

  int checks = 0;
  int fails  = 0;

  arm_exc_seq dut (
    .Clk           (Clk),
    .Rst           (Rst),
    .exc_req       (exc_req),
    .ret_addr      (ret_addr),
    .CPSR_cur      (CPSR_cur),
    .CPSR_in       (CPSR_in),
    .CPSR_write_en (CPSR_write_en),
    .CPSR_byte_w_en(CPSR_byte_w_en),
    .SPSR_in       (SPSR_in),
    .SPSR_write_en (SPSR_write_en),
    .SPSR_byte_w_en(SPSR_byte_w_en),
    .Rd_w_addr     (Rd_w_addr),
    .Rd_in         (Rd_in),
    .Rd_byte_w_en  (Rd_byte_w_en),
    .PC_in         (PC_in),
    .pc_load       (pc_load),
    .busy          (busy),
    .exc_ack       (exc_ack)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [6:0]  req;
    logic [31:0] cpsr;
    logic [31:0] ret;
    logic        taken;
    logic [31:0] ecpsr;
    logic [31:0] epc;
    logic [6:0]  eack;
  } vec_t;

  vec_t tv[10];

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic all_zero();
    return {CPSR_in, CPSR_write_en, CPSR_byte_w_en,
            SPSR_in, SPSR_write_en, SPSR_byte_w_en,
            Rd_w_addr, Rd_in, Rd_byte_w_en,
            PC_in, pc_load, busy, exc_ack} == '0;
  endfunction

  initial begin
    tv[0] = '{7'h20, 32'h10,       32'h104, 1, 32'h92,       32'h18, 7'h20};
    tv[1] = '{7'h70, 32'h10,       32'h200, 1, 32'h97,       32'h10, 7'h10};
    tv[2] = '{7'h20, 32'h93,       32'h300, 0, 32'h0,        32'h0,  7'h00};
    tv[3] = '{7'h40, 32'h93,       32'h400, 1, 32'hD1,       32'h1C, 7'h40};
    tv[4] = '{7'h06, 32'h10,       32'h500, 1, 32'h9B,       32'h04, 7'h02};
    tv[5] = '{7'h01, 32'h30,       32'h600, 1, 32'hD3,       32'h00, 7'h01};
    tv[6] = '{7'h08, 32'h1F,       32'h700, 1, 32'h97,       32'h0C, 7'h08};
    tv[7] = '{7'h40, 32'h40,       32'h800, 0, 32'h0,        32'h0,  7'h00};
    tv[8] = '{7'h28, 32'hF0000080, 32'h900, 1, 32'hF0000097, 32'h0C, 7'h08};
    tv[9] = '{7'h04, 32'h10,       32'hA00, 1, 32'h93,       32'h08, 7'h04};

    Rst = 1'b1;
    exc_req = '0;
    ret_addr = '0;
    CPSR_cur = 32'h10;
    tick();
    tick();
    chk("reset_zero", 32'(all_zero()), 32'd1);
    Rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      exc_req  = tv[i].req;
      CPSR_cur = tv[i].cpsr;
      ret_addr = tv[i].ret;
      tick();
      exc_req  = '0;
      CPSR_cur = 32'hFFFF_FFFF;
      ret_addr = 32'hDEAD_BEEF;
      if (tv[i].taken) begin
        chk($sformatf("v%0d_busy1", i), 32'(busy), 32'd1);
        chk($sformatf("v%0d_cwe", i), 32'(CPSR_write_en), 32'd1);
        chk($sformatf("v%0d_cbe", i), 32'(CPSR_byte_w_en), 32'hF);
        chk($sformatf("v%0d_cpsr", i), CPSR_in, tv[i].ecpsr);
        chk($sformatf("v%0d_s_off1", i),
            32'({SPSR_write_en, pc_load, exc_ack}), 32'd0);
        tick();
        chk($sformatf("v%0d_busy2", i), 32'(busy), 32'd1);
        chk($sformatf("v%0d_cwe2", i), 32'(CPSR_write_en), 32'd0);
        chk($sformatf("v%0d_swe", i), 32'(SPSR_write_en), 32'd1);
        chk($sformatf("v%0d_sbe", i), 32'(SPSR_byte_w_en), 32'hF);
        chk($sformatf("v%0d_spsr", i), SPSR_in, tv[i].cpsr);
        chk($sformatf("v%0d_rda", i), 32'(Rd_w_addr), 32'd14);
        chk($sformatf("v%0d_rd", i), Rd_in, tv[i].ret);
        chk($sformatf("v%0d_rbe", i), 32'(Rd_byte_w_en), 32'hF);
        tick();
        chk($sformatf("v%0d_busy3", i), 32'(busy), 32'd1);
        chk($sformatf("v%0d_pcl", i), 32'(pc_load), 32'd1);
        chk($sformatf("v%0d_pc", i), PC_in, tv[i].epc);
        chk($sformatf("v%0d_ack", i), 32'(exc_ack), 32'(tv[i].eack));
        chk($sformatf("v%0d_swe3", i), 32'(SPSR_write_en), 32'd0);
        tick();
        chk($sformatf("v%0d_idle", i), 32'(all_zero()), 32'd1);
      end else begin
        chk($sformatf("v%0d_mask1", i), 32'(all_zero()), 32'd1);
        tick();
        chk($sformatf("v%0d_mask2", i), 32'(all_zero()), 32'd1);
      end
    end

    // Reset while in BANK aborts the sequence
    exc_req  = 7'h20;
    CPSR_cur = 32'h10;
    ret_addr = 32'h104;
    tick();
    exc_req = '0;
    chk("rb_switch", 32'(CPSR_write_en), 32'd1);
    tick();
    chk("rb_bank", 32'(SPSR_write_en), 32'd1);
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    chk("rb_zero1", 32'(all_zero()), 32'd1);
    tick();
    chk("rb_zero2", 32'(all_zero()), 32'd1);
    exc_req = 7'h04;
    tick();
    exc_req = '0;
    chk("rb_accept", 32'(CPSR_in), 32'h93);
    tick();
    chk("rb_spsr", SPSR_in, 32'h10);
    tick();
    chk("rb_pc", PC_in, 32'h08);
    tick();
    chk("rb_idle", 32'(busy), 32'd0);

    // Reset in SWITCH: no ack in the following cycles
    exc_req = 7'h40;
    tick();
    exc_req = '0;
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    chk("rs_zero", 32'(all_zero()), 32'd1);
    tick();
    chk("rs_noack", 32'({pc_load, exc_ack}), 32'd0);

    // SWI held through the sequence, re-taken with new CPSR
    CPSR_cur = 32'h10;
    exc_req  = 7'h04;
    ret_addr = 32'h40;
    tick();
    CPSR_cur = 32'h93;
    ret_addr = 32'h80;
    chk("sh_c1", CPSR_in, 32'h93);
    tick();
    chk("sh_s1", SPSR_in, 32'h10);
    chk("sh_r1", Rd_in, 32'h40);
    tick();
    chk("sh_pc1", PC_in, 32'h08);
    tick();
    chk("sh_gap", 32'(busy), 32'd0);
    tick();
    chk("sh_busy2", 32'(busy), 32'd1);
    chk("sh_c2", CPSR_in, 32'h93);
    tick();
    exc_req = '0;
    chk("sh_s2", SPSR_in, 32'h93);
    chk("sh_r2", Rd_in, 32'h80);
    tick();
    chk("sh_ack2", 32'(exc_ack), 32'h04);
    tick();
    chk("sh_idle", 32'(all_zero()), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
